// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-ported, synchronous-read memory between the
// instruction-fetch port and the data load/store port. Data wins contention by
// default; a starvation counter forces a fetch grant after STARVE_LIMIT losses.
// Each access takes an issue cycle (ACCESS) and a response cycle (RESP), and the
// next grant may overlap the response so back-to-back accesses run every 2 cycles.
module imem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         starve_cnt_q, starve_cnt_d;
    logic                  owner_q, owner_d;      // 1 = data port owns the access
    logic                  we_q, we_d;
    logic                  err_q, err_d;          // misaligned data access
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;        // word index
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic arb_slot;
    logic grant_i;
    logic grant_d;

    // Fetch addresses are word aligned by contract; their low bits carry nothing.
    logic unused_if_low;
    assign unused_if_low = ^if_addr[1:0];

    // State and transaction registers; reset drops any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Arbitration: data first, unless fetch has lost STARVE_LIMIT times in a row.
    always_comb begin
        arb_slot = (state_q == IDLE) || (state_q == RESP);
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        if (arb_slot) begin
            if (if_req && d_req) begin
                if (starve_cnt_q == STARVE_MAX) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else if (if_req) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    // Next state, captured transaction and starvation count.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        owner_d      = owner_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE:    state_d = (grant_i || grant_d) ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = (grant_i || grant_d) ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase

        if (grant_i) begin
            owner_d      = 1'b0;
            we_d         = 1'b0;
            err_d        = 1'b0;
            addr_d       = {2'b00, if_addr[ADDR_WIDTH-1:2]};
            wdata_d      = '0;
            starve_cnt_d = '0;
        end else if (grant_d) begin
            owner_d = 1'b1;
            we_d    = d_we;
            err_d   = |d_addr[1:0];
            addr_d  = {2'b00, d_addr[ADDR_WIDTH-1:2]};
            wdata_d = d_wdata;
            if (if_req && (starve_cnt_q != STARVE_MAX)) begin
                starve_cnt_d = starve_cnt_q + CW'(1);
            end
        end
    end

    // Port and memory outputs; grants are masked while reset is asserted.
    always_comb begin
        if_gnt    = grant_i && !rst;
        d_gnt     = grant_d && !rst;
        mem_en    = (state_q == ACCESS) && !err_q;
        mem_we    = (state_q == ACCESS) && !err_q && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_rvalid = (state_q == RESP) && !owner_q;
        d_rvalid  = (state_q == RESP) && owner_q;
        d_err     = d_rvalid && err_q;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !we_q && !err_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed scenarios followed by random traffic.
// A predictor records the expected response of every grant in a queue and a
// separate monitor pops and compares whenever the DUT raises an rvalid.
module tb_imem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid, d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    imem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic load;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h00A00093 : (32'hC0DE0000 ^ (32'(i) * 32'h00010203));
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory array behind the arbiter: synchronous read, write on mem_we.
    logic [31:0] mem [0:255];
    initial forever begin
        @(posedge clk);
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // ---------------- reference model / predictor ----------------
    typedef struct {
        bit          port;   // 1 = data
        logic [31:0] data;
        bit          err;
        int          at;     // cycle the response is due
    } resp_t;

    resp_t       sb[$];
    logic [31:0] ref_mem [0:255];
    bit          busy;
    int          resp_at, acc_at;
    bit          acc_en, acc_we;
    logic [31:0] acc_addr, acc_wdata;
    int          losses;

    initial forever begin
        bit opp, exp_i, exp_d, exp_en;
        resp_t e;
        @(negedge clk);
        if (load) for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        if (rst) begin
            sb.delete();
            busy   = 0;
            losses = 0;
        end else begin
            exp_en = busy && (acc_at == cyc) && acc_en;
            chk("mem_en", mem_en, exp_en);
            if (exp_en) begin
                chk("mem_we", mem_we, acc_we);
                chk("mem_addr", mem_addr, acc_addr);
                if (acc_we) chk("mem_wdata", mem_wdata, acc_wdata);
            end
            // arbitration happens when nothing is outstanding or a response is due now
            opp   = !busy || (resp_at == cyc);
            exp_i = 0;
            exp_d = 0;
            if (opp) begin
                if (if_req && d_req) begin
                    if (losses >= LIMIT) exp_i = 1; else exp_d = 1;
                end else begin
                    exp_i = if_req;
                    exp_d = d_req;
                end
            end
            if (opp || if_gnt || d_gnt) begin
                chk("if_gnt", if_gnt, exp_i);
                chk("d_gnt", d_gnt, exp_d);
            end
            if (exp_i) losses = 0;
            else if (exp_d && if_req && losses < LIMIT) losses++;
            if (exp_i || exp_d) begin
                busy    = 1;
                resp_at = cyc + 2;
                acc_at  = cyc + 1;
                e.at    = cyc + 2;
                if (exp_i) begin
                    e.port    = 0;
                    e.err     = 0;
                    e.data    = ref_mem[if_addr[9:2]];
                    acc_en    = 1;
                    acc_we    = 0;
                    acc_addr  = if_addr >> 2;
                    acc_wdata = 0;
                end else begin
                    e.port    = 1;
                    e.err     = (d_addr[1:0] != 2'b00);
                    acc_en    = !e.err;
                    acc_we    = d_we;
                    acc_addr  = d_addr >> 2;
                    acc_wdata = d_wdata;
                    if (e.err || d_we) e.data = 0;
                    else e.data = ref_mem[d_addr[9:2]];
                    if (!e.err && d_we) ref_mem[d_addr[9:2]] = d_wdata;
                end
                sb.push_back(e);
            end else if (busy && resp_at == cyc) begin
                busy = 0;
            end
        end
    end

    // ---------------- response monitor ----------------
    logic [31:0] last_if_rdata, last_d_rdata;
    logic        last_d_err;

    initial forever begin
        resp_t e;
        @(negedge clk);
        if (!rst) begin
            if (sb.size() > 0 && sb[0].at < cyc) begin
                chk("missing_rvalid", 0, 1);
                void'(sb.pop_front());
            end
            if (if_rvalid || d_rvalid) begin
                chk("rvalid_exclusive", if_rvalid && d_rvalid, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_port", d_rvalid, e.port);
                    chk("resp_cycle", cyc, e.at);
                    if (d_rvalid) begin
                        chk("d_rdata", d_rdata, e.data);
                        chk("d_err", d_err, e.err);
                        last_d_rdata = d_rdata;
                        last_d_err   = d_err;
                    end else begin
                        chk("if_rdata", if_rdata, e.data);
                        chk("d_err_on_fetch", d_err, 0);
                        last_if_rdata = if_rdata;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit g_i, g_d;
    int g_cyc;

    task automatic cycle();
        @(negedge clk);
        g_i   = if_gnt;
        g_d   = d_gnt;
        g_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic i_txn(input logic [31:0] a);
        if_req  = 1;
        if_addr = a;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (g_i) break;
        end
        chk("if_gnt_timeout", g_i, 1);
        if_req = 0;
    endtask

    task automatic d_txn(input bit we, input logic [31:0] a, input logic [31:0] wd);
        d_req   = 1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (g_d) break;
        end
        chk("d_gnt_timeout", g_d, 1);
        d_req = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctrl"}, {if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, mem_we}, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        int gc[3];
        int n;
        bit seq[$];
        bit drop;

        rst = 1; load = 1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        load = 0;
        rst  = 0;

        // single fetch of word 0
        i_txn(32'h0);
        idle(3);
        chk("fetch_word0", last_if_rdata, 32'h00A00093);

        // data write then read
        d_txn(1, 32'h10, 32'hDEADBEEF);
        idle(3);
        chk("write_resp_rdata", last_d_rdata, 0);
        chk("write_resp_err", last_d_err, 0);
        d_txn(0, 32'h10, 0);
        idle(3);
        chk("read_back", last_d_rdata, 32'hDEADBEEF);

        // misaligned write must not touch memory
        d_txn(1, 32'h13, 32'h12345678);
        idle(3);
        chk("misaligned_err", last_d_err, 1);
        chk("misaligned_rdata", last_d_rdata, 0);
        d_txn(0, 32'h10, 0);
        idle(3);
        chk("misaligned_no_write", last_d_rdata, 32'hDEADBEEF);

        // back-to-back reads with d_req held
        d_req = 1; d_we = 0; d_addr = 32'h0;
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            cycle();
            if (g_d) begin
                gc[n] = g_cyc;
                n++;
                d_addr = d_addr + 4;
                if (n == 3) d_req = 0;
            end
        end
        chk("b2b_count", n, 3);
        chk("b2b_gap1", gc[1] - gc[0], 2);
        chk("b2b_gap2", gc[2] - gc[1], 2);
        idle(4);

        // a fetch to clear any starvation history, then full contention
        i_txn(32'h4);
        idle(3);
        if_req = 1; if_addr = 32'h40;
        d_req  = 1; d_we = 0; d_addr = 32'h20;
        for (int k = 0; k < 80 && (if_req || d_req); k++) begin
            cycle();
            if (g_i || g_d) begin
                seq.push_back(g_i);
                drop = (seq.size() > 10);
                if (drop && g_i) if_req = 0;
                if (drop && g_d) d_req = 0;
            end
        end
        chk("contention_drained", {if_req, d_req}, 0);
        for (int k = 0; k < 10; k++)
            chk($sformatf("contention_grant%0d", k), seq[k], (k % 5) == 4);
        idle(4);

        // reset while a fetch is in ACCESS
        i_txn(32'h8);
        rst = 1;
        #1;
        check_outputs_zero("reset_mid_access");
        @(negedge clk);
        chk("reset_no_rvalid_a", if_rvalid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_no_rvalid_b", if_rvalid, 0);
        @(posedge clk);
        #1;
        rst = 0;
        i_txn(32'h4);
        idle(3);
        chk("post_reset_fetch", last_if_rdata, init_word(1));

        // random traffic
        for (int k = 0; k < 800; k++) begin
            cycle();
            if (if_req && g_i) if_req = 0;
            if (d_req && g_d) d_req = 0;
            if (k < 760) begin
                if (!if_req && ($urandom_range(0, 2) == 0)) begin
                    if_req  = 1;
                    if_addr = 32'($urandom_range(0, 63)) << 2;
                end
                if (!d_req && ($urandom_range(0, 1) == 0)) begin
                    d_req   = 1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = (32'($urandom_range(0, 63)) << 2)
                            | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
                    d_wdata = $urandom;
                end
            end
        end
        chk("random_drained", {if_req, d_req}, 0);
        idle(4);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
